mlp_eval_sequencer: RTL

- Upstream test driver for the MLP inference core.
- Walks test indices 0..NUM_TESTS-1. For each index it pulses the core's start, waits for done and compares the 4-bit class output against a label ROM.
- Accumulates the correct-classification count and flags completion, or a hang via timeout.
- Sits between the board-level control (run button/host) and the MLP top.

---
 rtl/mlp_eval_sequencer_pkg.sv | 23 ++
 rtl/mlp_eval_sequencer_timeout_counter.sv | 29 ++
 rtl/mlp_eval_sequencer.sv | 121 ++++++++++++
 3 files changed

// File: rtl/mlp_eval_sequencer_pkg.sv
// Shared types and constants for the MLP evaluation sequencer and its timeout counter.
package mlp_eval_sequencer_pkg;

  localparam int CLS_W                  = 4;
  localparam int IDX_W                  = 10;
  localparam int NUM_TESTS_DEFAULT      = 750;
  localparam int TIMEOUT_CYCLES_DEFAULT = 65535;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    CMP,
    DONE_S,
    ERR
  } seq_state_e;

  // Scoreboard counters stick at all-ones instead of wrapping.
  function automatic logic [IDX_W-1:0] sat_inc(input logic [IDX_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/mlp_eval_sequencer_timeout_counter.sv
// Per-test watchdog: counts WAIT cycles and flags the terminal count at TIMEOUT_CYCLES-1.
module mlp_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic tc_o
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] cnt_q;

  assign tc_o = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Counting stops at the terminal value so the flag stays asserted until cleared.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (enable_i && !tc_o) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/mlp_eval_sequencer.sv
// Drives the MLP core through every test index, scores results against the label ROM
// and reports completion or a hung core.
module mlp_eval_sequencer
  import mlp_eval_sequencer_pkg::*;
#(
  parameter int NUM_TESTS      = NUM_TESTS_DEFAULT,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  output logic             mlp_start,
  output logic [IDX_W-1:0] mlp_test_num,
  input  logic             mlp_done,
  input  logic [CLS_W-1:0] mlp_out,
  output logic [IDX_W-1:0] label_addr,
  input  logic [CLS_W-1:0] label_data,
  output logic [IDX_W-1:0] correct_cnt,
  output logic [IDX_W-1:0] tested_cnt,
  output logic             busy,
  output logic             finished,
  output logic             error
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TESTS - 1);

  seq_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] correct_q, correct_d;
  logic [IDX_W-1:0] tested_q, tested_d;
  logic [CLS_W-1:0] result_q, result_d;
  logic             done_q;
  logic             done_rise;
  logic             tmo_clear, tmo_en, tmo_tc;

  assign done_rise = mlp_done & ~done_q;

  mlp_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear_i (tmo_clear),
    .enable_i(tmo_en),
    .tc_o    (tmo_tc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      correct_q <= '0;
      tested_q  <= '0;
      result_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      correct_q <= correct_d;
      tested_q  <= tested_d;
      result_q  <= result_d;
      done_q    <= mlp_done;
    end
  end

  // In WAIT a done edge beats a simultaneous timeout terminal count.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    correct_d = correct_q;
    tested_d  = tested_q;
    result_d  = result_q;
    tmo_clear = 1'b0;
    tmo_en    = 1'b0;
    case (state_q)
      IDLE, DONE_S, ERR: begin
        if (run) begin
          state_d   = ISSUE;
          idx_d     = '0;
          correct_d = '0;
          tested_d  = '0;
        end
      end
      ISSUE: begin
        tmo_clear = 1'b1;
        state_d   = WAIT;
      end
      WAIT: begin
        if (done_rise) begin
          result_d = mlp_out;
          state_d  = CMP;
        end else if (tmo_tc) begin
          state_d = ERR;
        end else begin
          tmo_en = 1'b1;
        end
      end
      CMP: begin
        if (result_q == label_data) correct_d = sat_inc(correct_q);
        tested_d = sat_inc(tested_q);
        if (idx_q == LAST_IDX) begin
          state_d = DONE_S;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = ISSUE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mlp_start    = (state_q == ISSUE);
  assign mlp_test_num = idx_q;
  assign label_addr   = idx_q;
  assign correct_cnt  = correct_q;
  assign tested_cnt   = tested_q;
  assign busy         = (state_q == ISSUE) || (state_q == WAIT) || (state_q == CMP);
  assign finished     = (state_q == DONE_S);
  assign error        = (state_q == ERR);

endmodule
